// File: rtl/alu_issue_stage.sv
// ID/EX issue stage feeding the ALU: decodes the ALU select, picks operand B
// and holds one registered op behind a valid/ready handshake.
module alu_issue_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic [15:0]       imm16,
  input  logic [1:0]        alu_op,
  input  logic [5:0]        funct,
  input  logic              alu_src,
  input  logic [REG_AW-1:0] rd_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic [2:0]        alu_sel,
  output logic [REG_AW-1:0] out_rd,
  output logic              illegal_op,
  output logic [CNT_W-1:0]  issue_count
);

  logic              valid_q;
  logic [DATA_W-1:0] op_a_q;
  logic [DATA_W-1:0] op_b_q;
  logic [2:0]        sel_q;
  logic [REG_AW-1:0] rd_q;
  logic              ill_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [2:0]        sel_d;
  logic              ill_d;
  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] op_b_d;
  logic              load;
  logic              accept;

  always_comb begin
    sel_d = 3'b011;
    ill_d = 1'b0;
    unique case (alu_op)
      2'b00: sel_d = 3'b010;
      2'b01: sel_d = 3'b110;
      2'b11: sel_d = 3'b001;
      2'b10: begin
        unique case (funct)
          6'b100000: sel_d = 3'b010;
          6'b100010: sel_d = 3'b110;
          6'b100100: sel_d = 3'b000;
          6'b100101: sel_d = 3'b001;
          6'b100111: sel_d = 3'b100;
          6'b100110: sel_d = 3'b101;
          6'b101010: sel_d = 3'b111;
          default: begin
            sel_d = 3'b011;
            ill_d = 1'b1;
          end
        endcase
      end
      default: sel_d = 3'b011;
    endcase
  end

  // or-imm is the only zero-extended form
  always_comb begin
    if (alu_op == 2'b11) begin
      imm_ext = {{(DATA_W-16){1'b0}}, imm16};
    end else begin
      imm_ext = {{(DATA_W-16){imm16[15]}}, imm16};
    end
  end

  assign op_b_d   = alu_src ? imm_ext : rt_data;
  assign in_ready = !flush && (!valid_q || out_ready);
  assign load     = in_valid && in_ready;
  assign accept   = valid_q && out_ready && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      sel_q   <= 3'b011;
      rd_q    <= '0;
      ill_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      if (flush) begin
        valid_q <= 1'b0;
      end else if (load) begin
        valid_q <= 1'b1;
        op_a_q  <= rs_data;
        op_b_q  <= op_b_d;
        sel_q   <= sel_d;
        rd_q    <= rd_addr;
        ill_q   <= ill_d;
      end else if (out_ready) begin
        valid_q <= 1'b0;
      end
      if (accept && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign out_valid   = valid_q;
  assign op_a        = op_a_q;
  assign op_b        = op_b_q;
  assign alu_sel     = sel_q;
  assign out_rd      = rd_q;
  assign illegal_op  = ill_q;
  assign issue_count = cnt_q;

endmodule
